// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit signed adder/subtractor between two
// requesters, returning the 5-bit result on a tagged valid/ready response.
module alu_share_arbiter #(
    parameter logic FIRST_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_sub,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_sub,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [4:0] rsp_data,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam int unsigned OPW = 4;
    localparam int unsigned RESW = 5;
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic            last_grant;
    logic            grant_c;
    logic            accept_c;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic            op_sub;
    logic            op_id;
    logic [RESW-1:0] sum_c;

    // Tie goes to whoever did not complete last; a lone valid always wins.
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign req0_ready = (state == ST_IDLE) && req0_valid && !grant_c;
    assign req1_ready = (state == ST_IDLE) && req1_valid && grant_c;
    assign accept_c   = req0_ready || req1_ready;
    assign busy       = (state != ST_IDLE);

    // Shared datapath: sign-extend to 5 bits so the result never overflows.
    always_comb begin : adder_substractor
        logic [RESW-1:0] a_ext;
        logic [RESW-1:0] b_ext;
        a_ext = {op_a[OPW-1], op_a};
        b_ext = {op_b[OPW-1], op_b} ^ {RESW{op_sub}};
        sum_c = a_ext + b_ext + RESW'(op_sub);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept_c) next_state = ST_CALC;
            ST_CALC: next_state = ST_RESP;
            ST_RESP: if (rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, result register and completion bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= ~FIRST_PRI;
            op_count   <= '0;
        end else begin
            if (accept_c) begin
                op_a   <= grant_c ? req1_a : req0_a;
                op_b   <= grant_c ? req1_b : req0_b;
                op_sub <= grant_c ? req1_sub : req0_sub;
                op_id  <= grant_c;
            end
            if (state == ST_CALC) begin
                rsp_data  <= sum_c;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if ((state == ST_RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
                last_grant <= rsp_id;
                op_count   <= op_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_sub;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_sub;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [4:0] rsp_data;
    logic [7:0] op_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    alu_share_arbiter #(.FIRST_PRI(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic sub);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return sub ? 5'(sa - sb) : 5'(sa + sb);
    endfunction

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_sub = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 0;
        @(posedge clk); #1;
    endtask

    // One uncontended operation with rsp_ready held high; starts and ends #1 after an edge in IDLE.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic sub, input logic [4:0] exp, input string tag);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        #1;
        chk({tag, "_ready"}, 8'(id ? req1_ready : req0_ready), 8'd1);
        chk({tag, "_other_ready"}, 8'(id ? req0_ready : req1_ready), 8'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, "_calc_valid"}, 8'(rsp_valid), 8'd0);
        chk({tag, "_calc_busy"}, 8'(busy), 8'd1);
        @(posedge clk); #1;
        chk({tag, "_rsp_valid"}, 8'(rsp_valid), 8'd1);
        chk({tag, "_rsp_data"}, 8'(rsp_data), 8'(exp));
        chk({tag, "_rsp_id"}, 8'(rsp_id), 8'(id));
        @(posedge clk); #1;
        exp_count++;
        chk({tag, "_done_valid"}, 8'(rsp_valid), 8'd0);
        chk({tag, "_op_count"}, op_count, 8'(exp_count));
    endtask

    initial begin
        // Reset with random inputs.
        rst_n = 1'b0;
        req0_valid = 1'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sub = 1'($urandom);
        req1_valid = 1'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sub = 1'($urandom);
        rsp_ready = 1'($urandom);
        #12;
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_id", 8'(rsp_id), 8'd0);
        chk("rst_rsp_data", 8'(rsp_data), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_op_count", op_count, 8'd0);
        clear_inputs();
        rsp_ready = 1'b0;
        #1;
        chk("rst_req0_ready", 8'(req0_ready), 8'd0);
        chk("rst_req1_ready", 8'(req1_ready), 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_rsp_valid", 8'(rsp_valid), 8'd0);
            chk("idle_busy", 8'(busy), 8'd0);
        end
        chk("idle_op_count", op_count, 8'd0);

        // Single add and the subtract/add extremes.
        run_op(1'b0, 4'b0111, 4'b0111, 1'b0, 5'b01110, "add_7_7");
        run_op(1'b1, 4'b1000, 4'b0111, 1'b1, 5'b10001, "sub_m8_7");
        run_op(1'b0, 4'b0011, 4'b0101, 1'b1, 5'b11110, "sub_3_5");
        run_op(1'b0, 4'b1000, 4'b1000, 1'b0, 5'b10000, "add_m8_m8");

        // Reset during CALC aborts the operation immediately.
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sub = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("midrst_in_calc", 8'(busy), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_op_count", op_count, 8'd0);
        chk("midrst_rsp_data", 8'(rsp_data), 8'd0);
        #3;
        rst_n = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 8'(rsp_valid), 8'd0);
        end

        // Contention: req0 computes 1+2=3, req1 computes 5-(-3)=8; grants must alternate 0,1.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'b1101; req1_sub = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("cont_ready0", 8'(req0_ready), 8'(k % 2 == 0));
            chk("cont_ready1", 8'(req1_ready), 8'(k % 2 == 1));
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("cont_rsp_id", 8'(rsp_id), 8'(k % 2));
            chk("cont_rsp_data", 8'(rsp_data), (k % 2 == 0) ? 8'd3 : 8'd8);
            @(posedge clk); #1;
            exp_count++;
        end
        chk("cont_op_count", op_count, 8'(exp_count));

        // Back-pressure: both still valid, hold rsp_ready low in RESP.
        chk("bp_grant0", 8'(req0_ready), 8'd1);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("bp_rsp_data", 8'(rsp_data), 8'd3);
            chk("bp_rsp_id", 8'(rsp_id), 8'd0);
            chk("bp_ready0", 8'(req0_ready), 8'd0);
            chk("bp_ready1", 8'(req1_ready), 8'd0);
            chk("bp_op_count", op_count, 8'(exp_count));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        chk("bp_done_valid", 8'(rsp_valid), 8'd0);
        chk("bp_done_count", op_count, 8'(exp_count));
        chk("bp_next_grant1", 8'(req1_ready), 8'd1);
        clear_inputs();

        // 256 operations wrap op_count back to 0.
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            req0_valid = 1'b1;
            req0_a = 4'(i);
            req0_b = 4'(i >> 4);
            req0_sub = 1'(i);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("wrap_rsp_data", 8'(rsp_data), 8'(model(req0_a, req0_b, req0_sub)));
            @(posedge clk); #1;
            if (i == 254) chk("wrap_count_255", op_count, 8'd255);
        end
        chk("wrap_count_0", op_count, 8'd0);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
